// File: rtl/gpmc_csr_bridge.sv
// -----------------------------------------------------------------------------
// gpmc_csr_bridge
//
// Purpose: connects the asynchronous GPMC host bus to a synchronous CSR bank.
// GPMC strobes are oversampled in the sys_clk domain (2-flop synchronisers).
// The address/data bus goes through a matching 2-stage pipe so that bus values
// and strobes line up. One CSR access is issued per host strobe. gpmc_wait
// stalls the host until the access has completed.
//
// Optional feature macro: GPMC_BRIDGE_ACK_EN
//   defined   : READ/WRITE complete on csr_ack. They give up after ACK_TIMEOUT
//               cycles: a read then returns 16'hDEAD and the sticky bus_err is
//               set.
//   undefined : csr_ack is ignored. A write takes one cycle. A read takes
//               CSR_LATENCY+1 cycles. bus_err is tied to 0.
//
// Ports:
//   sys_clk, sys_rst        clock, synchronous active-high reset
//   csr_adr/we/re/dat_w     CSR request side (we/re are 1-cycle pulses)
//   csr_dat_r, csr_ack      CSR response side
//   gpmc_a, gpmc_d_i        asynchronous GPMC address-high / muxed AD bus
//   gpmc_d_o, gpmc_d_oe     read data and output enable to the pad
//   gpmc_cs_n/we_n/oe_n/ale_n  asynchronous active-low GPMC strobes
//   gpmc_wait               1 = host must stall
//   bus_err                 sticky ACK-timeout flag
// -----------------------------------------------------------------------------
module gpmc_csr_bridge #(
   parameter int CSR_ADDR_WIDTH = 14,
   parameter int CSR_DATA_WIDTH = 8,
   parameter int CSR_LATENCY    = 1,
   parameter int ACK_TIMEOUT    = 255
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst,
   output logic [CSR_ADDR_WIDTH-1:0] csr_adr,
   output logic                      csr_we,
   output logic                      csr_re,
   output logic [CSR_DATA_WIDTH-1:0] csr_dat_w,
   input  logic [CSR_DATA_WIDTH-1:0] csr_dat_r,
   input  logic                      csr_ack,
   input  logic [9:0]                gpmc_a,
   input  logic [15:0]               gpmc_d_i,
   output logic [15:0]               gpmc_d_o,
   output logic                      gpmc_d_oe,
   input  logic                      gpmc_cs_n,
   input  logic                      gpmc_we_n,
   input  logic                      gpmc_oe_n,
   input  logic                      gpmc_ale_n,
   output logic                      gpmc_wait,
   output logic                      bus_err
);

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_HOLD} state_e;

   state_e state_q, state_d;

   // Strobe synchronisers. Index 1 is the synchronised output.
   logic [1:0] cs_sync_q, we_sync_q, oe_sync_q, ale_sync_q;
   // Bus pipe, as deep as the synchronisers so that bus and strobes align.
   logic [9:0]  a_p1_q, a_p2_q;
   logic [15:0] d_p1_q, d_p2_q;

   logic cs_n_s, we_n_s, oe_n_s, ale_n_s;
   assign cs_n_s  = cs_sync_q[1];
   assign we_n_s  = we_sync_q[1];
   assign oe_n_s  = oe_sync_q[1];
   assign ale_n_s = ale_sync_q[1];

   logic [25:0]               addr_q;
   logic [15:0]               cnt_q, cnt_d;
   logic [15:0]               rd_q, rd_d;
   logic                      is_rd_q, is_rd_d;
   logic [CSR_DATA_WIDTH-1:0] dat_w_q, dat_w_d;
   logic                      we_q, re_q, wait_q, d_oe_q;
   logic                      err_set;

   logic strobe_wr, strobe_rd, strobe_gone;
   assign strobe_wr   = !cs_n_s && !we_n_s;
   assign strobe_rd   = !cs_n_s && !oe_n_s;
   // The access ends when the host drops chip select or releases both strobes.
   // A strobe that is still held in HOLD therefore never starts a second access.
   assign strobe_gone = cs_n_s || (we_n_s && oe_n_s);

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default first, so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      is_rd_d = is_rd_q;
      dat_w_d = dat_w_q;
      err_set = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (strobe_wr) begin
               // A write wins when WE and OE are both low.
               state_d = ST_WRITE;
               is_rd_d = 1'b0;
               dat_w_d = d_p2_q[CSR_DATA_WIDTH-1:0];
               cnt_d   = '0;
            end else if (strobe_rd) begin
               state_d = ST_READ;
               is_rd_d = 1'b1;
`ifdef GPMC_BRIDGE_ACK_EN
               cnt_d   = '0;
`else
               cnt_d   = 16'(CSR_LATENCY);
`endif
            end
         end
         ST_WRITE: begin
`ifdef GPMC_BRIDGE_ACK_EN
            // An ack in the same cycle as csr_we is accepted.
            if (csr_ack) begin
               state_d = ST_HOLD;
            end else if (cnt_q == 16'(ACK_TIMEOUT - 1)) begin
               state_d = ST_HOLD;
               err_set = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`else
            state_d = ST_HOLD;
`endif
         end
         ST_READ: begin
`ifdef GPMC_BRIDGE_ACK_EN
            if (csr_ack) begin
               rd_d    = 16'(csr_dat_r);
               state_d = ST_HOLD;
            end else if (cnt_q == 16'(ACK_TIMEOUT - 1)) begin
               rd_d    = 16'hDEAD;
               err_set = 1'b1;
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`else
            // csr_re was issued on the entry cycle. The data is sampled
            // CSR_LATENCY cycles later.
            if (cnt_q == '0) begin
               rd_d    = 16'(csr_dat_r);
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
`endif
         end
         ST_HOLD: begin
            if (strobe_gone) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // flop samples the values from before the edge.
         cs_sync_q  <= 2'b11;
         we_sync_q  <= 2'b11;
         oe_sync_q  <= 2'b11;
         ale_sync_q <= 2'b11;
         a_p1_q     <= '0;
         a_p2_q     <= '0;
         d_p1_q     <= '0;
         d_p2_q     <= '0;
         addr_q     <= '0;
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         rd_q       <= '0;
         is_rd_q    <= 1'b0;
         dat_w_q    <= '0;
         we_q       <= 1'b0;
         re_q       <= 1'b0;
         wait_q     <= 1'b1;
         d_oe_q     <= 1'b0;
      end else begin
         cs_sync_q  <= {cs_sync_q[0],  gpmc_cs_n};
         we_sync_q  <= {we_sync_q[0],  gpmc_we_n};
         oe_sync_q  <= {oe_sync_q[0],  gpmc_oe_n};
         ale_sync_q <= {ale_sync_q[0], gpmc_ale_n};
         a_p1_q     <= gpmc_a;
         a_p2_q     <= a_p1_q;
         d_p1_q     <= gpmc_d_i;
         d_p2_q     <= d_p1_q;
         // The address follows the bus while ALE is low. It keeps the last value.
         if (!ale_n_s) addr_q <= {a_p2_q, d_p2_q};
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_q       <= rd_d;
         is_rd_q    <= is_rd_d;
         dat_w_q    <= dat_w_d;
         // The strobes are high only in the first cycle of WRITE or READ.
         we_q       <= (state_q == ST_IDLE) && (state_d == ST_WRITE);
         re_q       <= (state_q == ST_IDLE) && (state_d == ST_READ);
         wait_q     <= (state_d != ST_HOLD);
         d_oe_q     <= (state_q == ST_HOLD) && is_rd_q && !oe_n_s && !cs_n_s;
      end
   end

`ifdef GPMC_BRIDGE_ACK_EN
   logic bus_err_q;
   always_ff @(posedge sys_clk) begin
      if (sys_rst)      bus_err_q <= 1'b0;
      else if (err_set) bus_err_q <= 1'b1;
   end
   assign bus_err = bus_err_q;
   localparam int unused_latency = CSR_LATENCY;
`else
   assign bus_err = 1'b0;
   localparam int unused_timeout = ACK_TIMEOUT;
`endif

   // Collects signals that some builds or widths do not use.
   logic unused_sink;
   assign unused_sink = ^{csr_ack, err_set, addr_q, d_p2_q};

   assign csr_adr   = addr_q[CSR_ADDR_WIDTH-1:0];
   assign csr_we    = we_q;
   assign csr_re    = re_q;
   assign csr_dat_w = dat_w_q;
   assign gpmc_d_o  = rd_q;
   assign gpmc_d_oe = d_oe_q;
   assign gpmc_wait = wait_q;

endmodule

// File: tb/tb_gpmc_csr_bridge.sv
// -----------------------------------------------------------------------------
// tb_gpmc_csr_bridge
//
// Two bridges share one GPMC bus:
//   u_dut8  : 8-bit data, 14-bit address, latency 3
//   u_dut16 : 16-bit data, 20-bit address, latency 1
// Each bridge drives a small CSR memory. That memory presents valid read data
// only once its latency has elapsed. The expected contents are held in
// separate arrays that follow what the host wrote. Build with
// GPMC_BRIDGE_ACK_EN to exercise the ack/timeout path.
// -----------------------------------------------------------------------------
module tb_gpmc_csr_bridge;

   localparam int AW8 = 14, DW8 = 8, LAT8 = 3;
   localparam int AW16 = 20, DW16 = 16, LAT16 = 1;
   localparam int TMO = 8;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   always #5 sys_clk = ~sys_clk;

   logic [9:0]  gpmc_a = '0;
   logic [15:0] gpmc_d_i = '0;
   logic        gpmc_cs_n = 1'b1, gpmc_we_n = 1'b1, gpmc_oe_n = 1'b1, gpmc_ale_n = 1'b1;

   logic [AW8-1:0]  adr8;  logic we8, re8;  logic [DW8-1:0]  dw8, dr8;   logic ack8;
   logic [AW16-1:0] adr16; logic we16, re16; logic [DW16-1:0] dw16, dr16; logic ack16;
   logic [15:0] do8, do16;
   logic oe8, oe16, wait8, wait16, err8, err16;

   gpmc_csr_bridge #(.CSR_ADDR_WIDTH(AW8), .CSR_DATA_WIDTH(DW8), .CSR_LATENCY(LAT8),
                     .ACK_TIMEOUT(TMO)) u_dut8 (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .csr_adr(adr8), .csr_we(we8), .csr_re(re8), .csr_dat_w(dw8), .csr_dat_r(dr8),
      .csr_ack(ack8), .gpmc_a(gpmc_a), .gpmc_d_i(gpmc_d_i), .gpmc_d_o(do8),
      .gpmc_d_oe(oe8), .gpmc_cs_n(gpmc_cs_n), .gpmc_we_n(gpmc_we_n),
      .gpmc_oe_n(gpmc_oe_n), .gpmc_ale_n(gpmc_ale_n), .gpmc_wait(wait8), .bus_err(err8));

   gpmc_csr_bridge #(.CSR_ADDR_WIDTH(AW16), .CSR_DATA_WIDTH(DW16), .CSR_LATENCY(LAT16),
                     .ACK_TIMEOUT(TMO)) u_dut16 (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .csr_adr(adr16), .csr_we(we16), .csr_re(re16), .csr_dat_w(dw16), .csr_dat_r(dr16),
      .csr_ack(ack16), .gpmc_a(gpmc_a), .gpmc_d_i(gpmc_d_i), .gpmc_d_o(do16),
      .gpmc_d_oe(oe16), .gpmc_cs_n(gpmc_cs_n), .gpmc_we_n(gpmc_we_n),
      .gpmc_oe_n(gpmc_oe_n), .gpmc_ale_n(gpmc_ale_n), .gpmc_wait(wait16), .bus_err(err16));

   // ---------------------------------------------------------------- CSR slaves
   function automatic logic [7:0] init8(input int i);
      return 8'(i * 37 + 12);            // entry 16 holds 8'h5C
   endfunction
   function automatic logic [15:0] init16(input int i);
      return 16'(i * 4099 + 16'h1234);
   endfunction

   logic        slv_init = 1'b1;
   logic        ack_kill = 1'b0;
   logic [7:0]  smem8  [64];
   logic [15:0] smem16 [64];
   int age8 = 0, age16 = 0;
   int cyc = 0;
   int nwe8 = 0, nre8 = 0, nwe16 = 0, nre16 = 0;
   logic [AW8-1:0]  wadr8, radr8;   logic [7:0]  wdat8;
   logic [AW16-1:0] wadr16, radr16; logic [15:0] wdat16;

   always @(posedge sys_clk) begin
      cyc <= cyc + 1;
      if (slv_init) begin
         for (int i = 0; i < 64; i++) begin
            smem8[i]  <= init8(i);
            smem16[i] <= init16(i);
         end
      end else begin
         if (we8)  smem8[adr8[5:0]]   <= dw8;
         if (we16) smem16[adr16[5:0]] <= dw16;
      end
      if (re8)  age8  <= 1; else if (age8  != 0 && age8  < 100) age8  <= age8 + 1;
      if (re16) age16 <= 1; else if (age16 != 0 && age16 < 100) age16 <= age16 + 1;
      if (we8)  begin nwe8  <= nwe8 + 1;  wadr8  <= adr8;  wdat8  <= dw8;  end
      if (re8)  begin nre8  <= nre8 + 1;  radr8  <= adr8;  end
      if (we16) begin nwe16 <= nwe16 + 1; wadr16 <= adr16; wdat16 <= dw16; end
      if (re16) begin nre16 <= nre16 + 1; radr16 <= adr16; end
   end

   // Read data is valid only once the latency after csr_re has elapsed.
   // Before that the slave returns the inverted word.
   assign dr8   = (!re8  && age8  >= LAT8)  ? smem8[adr8[5:0]]    : ~smem8[adr8[5:0]];
   assign dr16  = (!re16 && age16 >= LAT16) ? smem16[adr16[5:0]]  : ~smem16[adr16[5:0]];
   assign ack8  = !ack_kill && (we8  || (!re8  && age8  >= LAT8));
   assign ack16 = !ack_kill && (we16 || (!re16 && age16 >= LAT16));

   // ---------------------------------------------------------------- model
   logic [7:0]  exp8  [64];
   logic [15:0] exp16 [64];

   int n_total = 0, n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic host_latch(input logic [25:0] addr);
      @(negedge sys_clk);
      gpmc_a     = addr[25:16];
      gpmc_d_i   = addr[15:0];
      gpmc_ale_n = 1'b0;
      repeat (4) @(negedge sys_clk);
      gpmc_ale_n = 1'b1;
      gpmc_d_i   = 16'($urandom);      // bus turnaround junk must not be latched
      repeat (3) @(negedge sys_clk);
   endtask

   // Asserts the strobes and returns, for each bridge, the number of cycles
   // until gpmc_wait falls. The result is -1 if it never falls.
   task automatic strobe_and_wait(input bit is_wr, input bit both, input logic [15:0] data,
                                  output int f8, output int f16);
      int t0;
      @(negedge sys_clk);
      gpmc_d_i  = is_wr ? data : 16'($urandom);
      gpmc_cs_n = 1'b0;
      if (is_wr) gpmc_we_n = 1'b0;
      if (!is_wr || both) gpmc_oe_n = 1'b0;
      t0  = cyc;
      f8  = -1;
      f16 = -1;
      for (int i = 0; i < 40 && (f8 < 0 || f16 < 0); i++) begin
         @(negedge sys_clk);
         if (f8  < 0 && !wait8)  f8  = cyc - t0;
         if (f16 < 0 && !wait16) f16 = cyc - t0;
      end
   endtask

   task automatic host_release();
      gpmc_cs_n = 1'b1;
      gpmc_we_n = 1'b1;
      gpmc_oe_n = 1'b1;
      repeat (4) @(negedge sys_clk);
   endtask

   task automatic host_access(input bit is_wr, input bit both, input logic [25:0] addr,
                              input logic [15:0] data, input int hold);
      int f8, f16, bw8, br8, bw16, br16;
      logic [5:0] ix;
      ix = addr[5:0];
      host_latch(addr);
      bw8 = nwe8; br8 = nre8; bw16 = nwe16; br16 = nre16;
      strobe_and_wait(is_wr, both, data, f8, f16);
      check("wait_fall8",  f8,  is_wr ? 4 : LAT8 + 4);
      check("wait_fall16", f16, is_wr ? 4 : LAT16 + 4);
      @(negedge sys_clk);
      check("d_oe8",  oe8,  !is_wr);
      check("d_oe16", oe16, !is_wr);
      if (!is_wr) begin
         check("rdata8",  do8,  {8'h00, exp8[ix]});
         check("rdata16", do16, exp16[ix]);
      end
      repeat (hold) @(negedge sys_clk);
      check("we_cnt8",  nwe8 - bw8,   is_wr);
      check("re_cnt8",  nre8 - br8,   !is_wr);
      check("we_cnt16", nwe16 - bw16, is_wr);
      check("re_cnt16", nre16 - br16, !is_wr);
      if (is_wr) begin
         check("wadr8",  wadr8,  addr[AW8-1:0]);
         check("wdat8",  wdat8,  data[7:0]);
         check("wadr16", wadr16, addr[AW16-1:0]);
         check("wdat16", wdat16, data);
         exp8[ix]  = data[7:0];
         exp16[ix] = data;
      end else begin
         check("radr8",  radr8,  addr[AW8-1:0]);
         check("radr16", radr16, addr[AW16-1:0]);
      end
      host_release();
      check("idle_wait8",  wait8,  1'b1);
      check("idle_wait16", wait16, 1'b1);
      check("idle_oe8",    oe8,    1'b0);
      check("bus_err8",    err8,   1'b0);
   endtask

   // ---------------------------------------------------------------- stimulus
   logic [25:0] pool [6];

   initial begin
      int f8, f16, b8, b16;
      for (int i = 0; i < 64; i++) begin
         exp8[i]  = init8(i);
         exp16[i] = init16(i);
      end
      repeat (3) @(negedge sys_clk);
      slv_init = 1'b0;
      check("rst_adr8",   adr8,   '0);
      check("rst_dw8",    dw8,    '0);
      check("rst_we8",    we8,    1'b0);
      check("rst_re8",    re8,    1'b0);
      check("rst_do8",    do8,    16'h0);
      check("rst_oe8",    oe8,    1'b0);
      check("rst_wait8",  wait8,  1'b1);
      check("rst_err8",   err8,   1'b0);
      check("rst_adr16",  adr16,  '0);
      check("rst_wait16", wait16, 1'b1);
      check("rst_oe16",   oe16,   1'b0);
      sys_rst = 1'b0;
      repeat (3) @(negedge sys_clk);

      // Directed write, then a read of a preloaded location.
      host_access(1'b1, 1'b0, {10'h001, 16'h0234}, 16'h00A5, 2);
      host_access(1'b0, 1'b0, {10'h000, 16'h0010}, 16'h0000, 3);
      check("rd_5c", do8, 16'h005C);
      // Full 16-bit write and read-back.
      host_access(1'b1, 1'b0, {10'h2A5, 16'h3C07}, 16'hBEEF, 1);
      host_access(1'b0, 1'b0, {10'h2A5, 16'h3C07}, 16'h0000, 1);
      check("rd_beef16", do16, 16'hBEEF);
      check("rd_ef8",    do8,  16'h00EF);
      // WE and OE low together, held for 20 cycles: exactly one write.
      host_access(1'b1, 1'b1, {10'h013, 16'h0022}, 16'h7E81, 20);

      // Reset while both bridges are in READ.
      host_latch({10'h000, 16'h0030});
      @(negedge sys_clk);
      gpmc_cs_n = 1'b0;
      gpmc_oe_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      sys_rst   = 1'b1;
      gpmc_cs_n = 1'b1;
      gpmc_oe_n = 1'b1;
      repeat (2) @(negedge sys_clk);
      check("rstmid_wait8",  wait8,  1'b1);
      check("rstmid_wait16", wait16, 1'b1);
      check("rstmid_oe8",    oe8,    1'b0);
      b8 = nre8; b16 = nre16;
      sys_rst = 1'b0;
      repeat (6) @(negedge sys_clk);
      check("rstmid_re8",   nre8 - b8,   0);
      check("rstmid_re16",  nre16 - b16, 0);
      check("rstmid_idle8", wait8, 1'b1);
      host_access(1'b0, 1'b0, {10'h000, 16'h0030}, 16'h0000, 0);

      // Randomised traffic over a small address pool so that read-backs hit.
      for (int i = 0; i < 6; i++) pool[i] = 26'($urandom);
      for (int n = 0; n < 24; n++) begin
         bit wr;
         wr = 1'($urandom_range(0, 1));
         host_access(wr, wr && ($urandom_range(0, 3) == 0), pool[$urandom_range(0, 5)],
                     16'($urandom), $urandom_range(0, 8));
      end

`ifdef GPMC_BRIDGE_ACK_EN
      // No ack at all: both bridges time out and report the error.
      ack_kill = 1'b1;
      host_latch({10'h000, 16'h0021});
      strobe_and_wait(1'b0, 1'b0, 16'h0000, f8, f16);
      check("tmo_wait8",  f8,  TMO + 3);
      check("tmo_wait16", f16, TMO + 3);
      @(negedge sys_clk);
      check("tmo_data8",  do8,   16'hDEAD);
      check("tmo_data16", do16,  16'hDEAD);
      check("tmo_err8",   err8,  1'b1);
      check("tmo_err16",  err16, 1'b1);
      host_release();
      ack_kill = 1'b0;
      check("tmo_sticky8", err8, 1'b1);
      sys_rst = 1'b1;
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
      check("tmo_clr8",  err8,  1'b0);
      check("tmo_clr16", err16, 1'b0);
`else
      f8 = 0; f16 = 0;
      check("noack_err16", err16, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
